bird_ctrl: RTL and testbench
============================

Name: bird_ctrl

Overview:
- Frame-rate sequencer for the bird physics datapath.
- Divides the system clock into game frames and issues one state code per cycle on `cur_state`, in this order per frame: jump-or-gravity, then position update, then bounds check.
- Detects jump presses, tracks alive/dead game state, and restarts the bird on `start`.
- Sits between the top level (buttons, VGA frame timing) and the bird datapath.

Parameters:
- FRAME_DIV, 833334: clock cycles per game frame (60 Hz at 50 MHz). Must be >= 8.
- Y_MAX, 8'd112: `bird_y` at or above this value means the bird has hit the ground.
- Y_WRAP, 8'd200: `bird_y` above this value means the position wrapped negative (ceiling hit).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  synchronous level; rising edge starts or restarts a game
- jump  in  1  raw button input, asynchronous to clk
- bird_y  in  8  current bird y from the datapath
- cur_state  out  2  datapath command:
  - 2'd0 UPDATE_Y (y += vy)
  - 2'd1 UPDATE_VY (vy -= gravity)
  - 2'd2 LOAD_JUMP (vy <= jump velocity)
  - 2'd3 HOLD (no change)
- bird_init  out  1  one-cycle pulse: datapath reloads y=60, vy=0
- frame_done  out  1  one-cycle pulse after each completed bounds check
- game_over  out  1  level, high while in DEAD

Behaviour:
- Reset (async) values:
  - FSM = IDLE
  - cur_state = 2'd3
  - bird_init = 0, frame_done = 0, game_over = 0
  - frame counter = 0
  - jump_pending = 0
  - synchronizer and edge registers = 0
- Jump input conditioning:
  - `jump` passes through a 2-flop synchronizer, then a rising-edge detector.
  - Press-to-edge latency is 3 clk.
- `start` has a rising-edge detector with no synchronizer.
- FSM states and `cur_state` per state (all outputs registered, one cycle per state unless noted):
  - IDLE: cur_state=HOLD. On start edge, go to INIT.
  - INIT: bird_init=1, cur_state=HOLD. Clear frame counter and jump_pending. Go to WAIT.
  - WAIT: cur_state=HOLD. Frame counter increments each cycle. When counter == FRAME_DIV-1, reset counter to 0 and go to JUMP if jump_pending, else to GRAV.
  - JUMP: cur_state=2'd2. Clear jump_pending. Go to MOVE.
  - GRAV: cur_state=2'd1. Go to MOVE.
  - MOVE: cur_state=2'd0. Go to CHECK.
  - CHECK: cur_state=HOLD. Sample bird_y, which is valid because the datapath updated during MOVE.
    - If bird_y >= Y_MAX or bird_y > Y_WRAP: go to DEAD. frame_done is not pulsed.
    - Otherwise: frame_done=1 and go to WAIT.
  - DEAD: game_over=1, cur_state=HOLD. On start edge, go to INIT; game_over drops in the same cycle INIT is entered.
- The frame counter runs only in WAIT. It is cleared in INIT and holds 0 in IDLE and DEAD.
- Frame period is exactly FRAME_DIV + 3 cycles (the WAIT dwell plus the JUMP/GRAV, MOVE and CHECK states).
- jump_pending:
  - Set by a jump edge in WAIT, JUMP, GRAV, MOVE or CHECK.
  - A jump edge in the same cycle as the JUMP-state clear leaves pending = 1 (set wins); that press is served next frame.
  - Multiple edges within one frame collapse into a single jump.
  - Edges in IDLE, INIT and DEAD are ignored.
- A start edge outside IDLE/DEAD is ignored; a game cannot be restarted mid-frame.
- Reset asserted mid-frame returns to IDLE within the same cycle (async). The datapath is not touched until the next INIT.
- All comparisons are unsigned 8-bit. Y_WRAP catches underflow because the datapath wraps silently.

Decomposition:
- Shared package `bird_pkg` holds:
  - cur_state encodings UPDATE_Y=0, UPDATE_VY=1, LOAD_JUMP=2, HOLD=3, shared with the datapath so both sides use one definition;
  - FSM state enum (IDLE, INIT, WAIT, JUMP, GRAV, MOVE, CHECK, DEAD);
  - default Y_MAX and Y_WRAP constants.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge pulse, with async active-high reset. Instantiated for `jump`; reusable by other button inputs.

Test Plan:
- Reset then idle: with no start edge for 100 cycles → cur_state=3, game_over=0, bird_init never pulses.
- Frame cadence (FRAME_DIV=8):
  - Stimulus: start pulse, bird_y held at 60.
  - Response: bird_init pulses 1 cycle after the start edge, then the repeating sequence 8×HOLD, 1, 0, HOLD.
  - Required: frame_done pulses every 11 cycles.
- Jump service:
  - Stimulus: jump held high for 2 cycles during WAIT.
  - Response: the next frame issues 2'd2 instead of 2'd1, and the frame after that issues 2'd1.
  - Stimulus: two presses within one frame → exactly one 2'd2.
  - Stimulus: a press coinciding with the JUMP cycle → 2'd2 in the next frame as well.
- Ground and ceiling:
  - bird_y=112 at CHECK → DEAD, game_over=1, no frame_done, cur_state stays 3.
  - bird_y=111 → continue.
  - bird_y=201 → DEAD.
- Restart and ignore:
  - jump edges in DEAD → no effect.
  - start edge in DEAD → INIT: bird_init pulse, game_over=0 next cycle, counter restarts from 0.
- Async reset mid-MOVE:
  - Stimulus: assert reset between clock edges.
  - Response: outputs go to reset values immediately. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared definitions for the bird sequencer and the bird physics datapath.
//   - cur_state command encodings (one definition for both sides)
//   - sequencer FSM state enum
//   - default playfield bounds and the bounds-check helper
package bird_pkg;

    // Datapath commands carried on cur_state
    localparam logic [1:0] UPDATE_Y  = 2'd0;  // y += vy
    localparam logic [1:0] UPDATE_VY = 2'd1;  // vy -= gravity
    localparam logic [1:0] LOAD_JUMP = 2'd2;  // vy <= jump velocity
    localparam logic [1:0] HOLD      = 2'd3;  // no change

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWait,
        StJump,
        StGrav,
        StMove,
        StCheck,
        StDead
    } bird_state_e;

    localparam logic [7:0] Y_MAX_DEF  = 8'd112;
    localparam logic [7:0] Y_WRAP_DEF = 8'd200;

    // The datapath wraps silently, so a small negative y shows up as a large
    // unsigned value; anything above y_wrap is treated as a ceiling hit.
    function automatic logic out_of_bounds(input logic [7:0] y,
                                           input logic [7:0] y_max,
                                           input logic [7:0] y_wrap);
        return (y >= y_max) || (y > y_wrap);
    endfunction

endpackage

// File: rtl/bird_ctrl_sync_edge.sv
// sync_edge: two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   din    in  raw asynchronous input
//   pulse  out one-cycle pulse on each synchronized rising edge of din
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/bird_ctrl.sv
// bird_ctrl: frame-rate sequencer for the bird physics datapath.
// Each game frame waits FRAME_DIV cycles, then issues jump-or-gravity,
// position update and a bounds check, one datapath command per cycle.
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous, active-high reset
//   start       in  synchronous level; rising edge starts/restarts a game
//   jump        in  raw button, asynchronous to clk
//   bird_y      in  current bird y from the datapath
//   cur_state   out datapath command (see bird_pkg)
//   bird_init   out one-cycle pulse: datapath reloads y/vy
//   frame_done  out one-cycle pulse after each passed bounds check
//   game_over   out level, high while dead
module bird_ctrl
    import bird_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 833334,
    parameter logic [7:0]  Y_MAX     = Y_MAX_DEF,
    parameter logic [7:0]  Y_WRAP    = Y_WRAP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       jump,
    input  logic [7:0] bird_y,
    output logic [1:0] cur_state,
    output logic       bird_init,
    output logic       frame_done,
    output logic       game_over
);

    localparam int unsigned CntW = $clog2(FRAME_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(FRAME_DIV - 1);

    bird_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic            jump_pending_q;
    logic            start_q;
    logic            start_edge;
    logic            jump_edge;
    logic            in_frame;

    sync_edge u_jump_sync (
        .clk   (clk),
        .reset (reset),
        .din   (jump),
        .pulse (jump_edge)
    );

    // start is already synchronous; only an edge detector is needed
    assign start_edge = start & ~start_q;
    assign in_frame   = (state_q == StWait) || (state_q == StJump) || (state_q == StGrav) ||
                        (state_q == StMove) || (state_q == StCheck);

    // Outputs are assigned alongside each transition so they line up with the
    // state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cur_state      <= HOLD;
            bird_init      <= 1'b0;
            frame_done     <= 1'b0;
            game_over      <= 1'b0;
            cnt_q          <= '0;
            jump_pending_q <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            start_q    <= start;
            bird_init  <= 1'b0;
            frame_done <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q   <= StInit;
                        bird_init <= 1'b1;
                    end
                end
                StInit: begin
                    state_q        <= StWait;
                    cur_state      <= HOLD;
                    cnt_q          <= '0;
                    jump_pending_q <= 1'b0;
                end
                StWait: begin
                    if (cnt_q == CntMax) begin
                        cnt_q <= '0;
                        if (jump_pending_q) begin
                            state_q   <= StJump;
                            cur_state <= LOAD_JUMP;
                        end else begin
                            state_q   <= StGrav;
                            cur_state <= UPDATE_VY;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StJump: begin
                    state_q        <= StMove;
                    cur_state      <= UPDATE_Y;
                    jump_pending_q <= 1'b0;
                end
                StGrav: begin
                    state_q   <= StMove;
                    cur_state <= UPDATE_Y;
                end
                StMove: begin
                    state_q   <= StCheck;
                    cur_state <= HOLD;
                end
                StCheck: begin
                    // bird_y reflects the update issued during MOVE
                    if (out_of_bounds(bird_y, Y_MAX, Y_WRAP)) begin
                        state_q   <= StDead;
                        game_over <= 1'b1;
                    end else begin
                        state_q    <= StWait;
                        frame_done <= 1'b1;
                    end
                end
                StDead: begin
                    if (start_edge) begin
                        state_q   <= StInit;
                        game_over <= 1'b0;
                        bird_init <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cur_state <= HOLD;
                end
            endcase

            // Placed after the case so a new press beats the clear in JUMP;
            // that press is then served in the following frame.
            if (jump_edge && in_frame) begin
                jump_pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bird_ctrl.sv
module tb_bird_ctrl;
    import bird_pkg::*;

    localparam int unsigned FD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       jump;
    logic [7:0] bird_y;
    logic [1:0] cur_state;
    logic       bird_init;
    logic       frame_done;
    logic       game_over;

    always #5 clk = ~clk;

    bird_ctrl #(
        .FRAME_DIV (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .jump       (jump),
        .bird_y     (bird_y),
        .cur_state  (cur_state),
        .bird_init  (bird_init),
        .frame_done (frame_done),
        .game_over  (game_over)
    );

    typedef struct {
        logic       start;
        logic       jump;
        logic [7:0] y;
        logic [1:0] cs;
        logic       bi;
        logic       fd;
        logic       go;
    } vec_t;

    vec_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] y_cur    = 8'd60;

    function automatic vec_t mk(input logic s, input logic j, input logic [1:0] cs,
                                input logic bi, input logic fd, input logic go);
        vec_t v;
        v.start = s;
        v.jump  = j;
        v.y     = y_cur;
        v.cs    = cs;
        v.bi    = bi;
        v.fd    = fd;
        v.go    = go;
        return v;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: cs/bi/fd/go got %b required %b at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(negedge clk);
        start  = v.start;
        jump   = v.jump;
        bird_y = v.y;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({name, " empty scoreboard"}, 5'b0, 5'b1);
        end else begin
            e = sb_q.pop_front();
            check(name, {cur_state, bird_init, frame_done, game_over},
                  {e.cs, e.bi, e.fd, e.go});
        end
    endtask

    // One game frame: 8 WAIT, JUMP/GRAV, MOVE, CHECK. fd0 is the frame_done
    // expected in the first WAIT cycle (set when the frame follows a passed check).
    task automatic run_frame(input string name, input logic [1:0] mv, input logic fd0,
                             input logic [10:0] jmask, input logic [10:0] smask,
                             input int n = 11);
        vec_t tbl[11];
        for (int i = 0; i < 11; i++) tbl[i] = mk(smask[i], jmask[i], HOLD, 1'b0, 1'b0, 1'b0);
        tbl[0].fd = fd0;
        tbl[8].cs = mv;
        tbl[9].cs = UPDATE_Y;
        for (int i = 0; i < n; i++) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    initial begin
        vec_t dead_tbl[8];

        reset  = 1'b1;
        start  = 1'b0;
        jump   = 1'b0;
        bird_y = 8'd60;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {cur_state, bird_init, frame_done, game_over}, {HOLD, 3'b000});
        @(negedge clk);
        reset = 1'b0;

        // Idle: nothing happens without a start edge
        for (int i = 0; i < 100; i++) apply(mk(0, 0, HOLD, 0, 0, 0), "idle");

        // Cadence
        apply(mk(1, 0, HOLD, 1, 0, 0), "start_init");
        run_frame("cad0", UPDATE_VY, 1'b0, '0, '0);
        run_frame("cad1", UPDATE_VY, 1'b1, '0, '0);

        // Jump held 2 cycles in WAIT, plus a mid-frame start edge that must be ignored
        run_frame("jmp_a", LOAD_JUMP, 1'b1, 11'b000_0000_0110, 11'b000_0000_1000);
        run_frame("jmp_b", UPDATE_VY, 1'b1, '0, '0);

        // Two presses in one frame collapse to one
        run_frame("two_a", LOAD_JUMP, 1'b1, 11'b000_0001_0010, '0);
        run_frame("two_b", UPDATE_VY, 1'b1, '0, '0);

        // Second press lands in the JUMP cycle: served next frame too
        run_frame("coin_a", LOAD_JUMP, 1'b1, 11'b000_1000_0010, '0);
        run_frame("coin_b", LOAD_JUMP, 1'b1, '0, '0);
        run_frame("coin_c", UPDATE_VY, 1'b1, '0, '0);

        // Bounds: 111 continues, 112 dies
        y_cur = 8'd111;
        run_frame("y111", UPDATE_VY, 1'b1, '0, '0);
        y_cur = 8'd112;
        apply(mk(0, 0, HOLD, 0, 0, 1), "ground_dead");
        y_cur = 8'd60;

        // Jump edges in DEAD are ignored, then start restarts
        dead_tbl[0] = mk(0, 1, HOLD, 0, 0, 1);
        dead_tbl[1] = mk(0, 1, HOLD, 0, 0, 1);
        for (int i = 2; i < 7; i++) dead_tbl[i] = mk(0, 0, HOLD, 0, 0, 1);
        dead_tbl[7] = mk(1, 0, HOLD, 1, 0, 0);
        for (int i = 0; i < 8; i++) apply(dead_tbl[i], $sformatf("dead_seq[%0d]", i));
        run_frame("restart", UPDATE_VY, 1'b0, '0, '0);

        // Ceiling (wrapped) hit
        y_cur = 8'd201;
        apply(mk(0, 0, HOLD, 0, 0, 1), "ceiling_dead");
        y_cur = 8'd60;
        apply(mk(0, 0, HOLD, 0, 0, 1), "dead_hold");
        apply(mk(1, 0, HOLD, 1, 0, 0), "restart2_init");

        // Async reset while in MOVE
        run_frame("pre_rst", UPDATE_VY, 1'b0, '0, '0, 10);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {cur_state, bird_init, frame_done, game_over}, {HOLD, 3'b000});
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) apply(mk(0, 0, HOLD, 0, 0, 0), "post_rst_idle");
        apply(mk(1, 0, HOLD, 1, 0, 0), "post_rst_init");
        run_frame("post_rst", UPDATE_VY, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
